// File: rtl/uart_controller_if.sv
// uart_controller_if: parallel byte handshake between fabric logic and the UART.
interface uart_controller_if #(parameter int BYTE_W = 8);
  logic [BYTE_W-1:0] TX_DATA;
  logic              TX_LOAD;
  logic              TX_LOAD_OKAY;
  logic [BYTE_W-1:0] RX_DATA;
  logic              RX_DATA_READY;
  modport master (output TX_DATA, TX_LOAD, input TX_LOAD_OKAY, RX_DATA, RX_DATA_READY);
  modport slave (input TX_DATA, TX_LOAD, output TX_LOAD_OKAY, RX_DATA, RX_DATA_READY);
endinterface

// File: rtl/uart_controller.sv
// uart_controller: full-duplex 8N1 UART, independent TX/RX engines sharing one baud divider.
module uart_controller #(
  parameter int SYSCLK_FREQ = 24000000,
  parameter int BAUDRATE    = 500000,
  parameter int BYTE_W      = 8
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic enable,
  input  logic RX_LINE,
  output logic TX_LINE,
  uart_controller_if.slave bus
);
  localparam int DIV = SYSCLK_FREQ / BAUDRATE;
  localparam int CW  = $clog2(DIV);
  localparam int IW  = $clog2(BYTE_W + 1);
  localparam logic [CW-1:0] D = CW'(DIV - 1);
  localparam logic [CW-1:0] H = CW'(DIV / 2 - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} st_e;
  st_e               tx_st_q, rx_st_q;
  logic [CW-1:0]     tx_cnt_q, rx_cnt_q;
  logic [IW-1:0]     tx_idx_q, rx_idx_q;
  logic [BYTE_W-1:0] tx_sh_q, rx_sh_q, rx_data_q;
  logic              tx_line_q, tx_ok_q, rx_rdy_q;
  logic              rx_s1_q, rx_s2_q, rx_prev_q;
  assign TX_LINE           = tx_line_q;
  assign bus.TX_LOAD_OKAY  = tx_ok_q;
  assign bus.RX_DATA       = rx_data_q;
  assign bus.RX_DATA_READY = rx_rdy_q;
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      tx_st_q   <= IDLE;
      tx_cnt_q  <= '0;
      tx_idx_q  <= '0;
      tx_sh_q   <= '0;
      tx_line_q <= 1'b1;
      tx_ok_q   <= 1'b0;
    end else if (!enable) begin
      tx_st_q   <= IDLE;
      tx_cnt_q  <= '0;
      tx_idx_q  <= '0;
      tx_line_q <= 1'b1;
      tx_ok_q   <= 1'b0;
    end else begin
      unique case (tx_st_q)
        IDLE: begin
          tx_line_q <= 1'b1;
          tx_ok_q   <= 1'b1;
          if (tx_ok_q && bus.TX_LOAD) begin
            tx_sh_q   <= bus.TX_DATA;
            tx_st_q   <= START;
            tx_cnt_q  <= '0;
            tx_line_q <= 1'b0;
            tx_ok_q   <= 1'b0;
          end
        end
        START: begin
          tx_cnt_q <= (tx_cnt_q == D) ? '0 : tx_cnt_q + CW'(1);
          if (tx_cnt_q == D) begin
            tx_st_q   <= DATA;
            tx_idx_q  <= '0;
            tx_line_q <= tx_sh_q[0];
            tx_sh_q   <= tx_sh_q >> 1;
          end
        end
        DATA: begin
          tx_cnt_q <= (tx_cnt_q == D) ? '0 : tx_cnt_q + CW'(1);
          if (tx_cnt_q == D) begin
            tx_idx_q  <= tx_idx_q + IW'(1);
            tx_st_q   <= (tx_idx_q == IW'(BYTE_W - 1)) ? STOP : DATA;
            tx_line_q <= (tx_idx_q == IW'(BYTE_W - 1)) ? 1'b1 : tx_sh_q[0];
            tx_sh_q   <= tx_sh_q >> 1;
          end
        end
        STOP: begin
          tx_cnt_q <= (tx_cnt_q == D) ? '0 : tx_cnt_q + CW'(1);
          if (tx_cnt_q == D) begin
            tx_st_q <= IDLE;
            tx_ok_q <= 1'b1;
          end
        end
      endcase
    end
  end
  // rx_prev_q lags the synchronised line so a start needs a seen-high-then-low transition
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_st_q   <= IDLE;
      rx_cnt_q  <= '0;
      rx_idx_q  <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      rx_rdy_q  <= 1'b0;
    end else begin
      rx_s1_q   <= RX_LINE;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_rdy_q  <= 1'b0;
      if (!enable) begin
        rx_st_q  <= IDLE;
        rx_cnt_q <= '0;
        rx_idx_q <= '0;
      end else begin
        unique case (rx_st_q)
          IDLE: begin
            rx_cnt_q <= '0;
            if (rx_prev_q && !rx_s2_q) rx_st_q <= START;
          end
          START: begin
            rx_cnt_q <= (rx_cnt_q == H) ? '0 : rx_cnt_q + CW'(1);
            if (rx_cnt_q == H) begin
              rx_idx_q <= '0;
              rx_st_q  <= rx_s2_q ? IDLE : DATA;
            end
          end
          DATA: begin
            rx_cnt_q <= (rx_cnt_q == D) ? '0 : rx_cnt_q + CW'(1);
            if (rx_cnt_q == D) begin
              rx_sh_q  <= {rx_s2_q, rx_sh_q[BYTE_W-1:1]};
              rx_idx_q <= rx_idx_q + IW'(1);
              if (rx_idx_q == IW'(BYTE_W - 1)) rx_st_q <= STOP;
            end
          end
          STOP: begin
            rx_cnt_q <= (rx_cnt_q == D) ? '0 : rx_cnt_q + CW'(1);
            if (rx_cnt_q == D) begin
              rx_st_q <= IDLE;
              if (rx_s2_q) begin
                rx_data_q <= rx_sh_q;
                rx_rdy_q  <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_controller.sv
// tb_uart_controller: directed + random loopback checks against a frame-level reference model.
module tb_uart_controller;
  localparam int DIV = 24000000 / 500000;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, loop = 1'b0, rx_drv = 1'b1;
  logic tx_line, rx_line;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] last_good = 8'h00;
  int errors = 0, checks = 0;
  uart_controller_if #(.BYTE_W(8)) bus();
  uart_controller dut (.sys_clk(clk), .rst(rst), .enable(enable), .RX_LINE(rx_line), .TX_LINE(tx_line), .bus(bus));
  assign rx_line = loop ? tx_line : rx_drv;
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.RX_DATA_READY === 1'b1) got_q.push_back(bus.RX_DATA);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic frame_bit(input logic [7:0] b, input int j);
    return (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j-1];
  endfunction
  task automatic send(input logic [7:0] b, input bit inject);
    int ok_low = 0;
    for (int i = 0; i < 2000 && bus.TX_LOAD_OKAY !== 1'b1; i++) @(negedge clk);
    chk("tx_ready", bus.TX_LOAD_OKAY, 1);
    bus.TX_DATA = b;
    bus.TX_LOAD = 1'b1;
    for (int c = 1; c <= 10 * DIV + 1; c++) begin
      @(negedge clk);
      bus.TX_LOAD = inject && c == 400;
      if (inject && c == 400) bus.TX_DATA = 8'h81;
      if (bus.TX_LOAD_OKAY === 1'b0) ok_low++;
      if ((c - 1) % DIV == DIV / 2) chk($sformatf("tx_%0h_bit%0d", b, (c - 1) / DIV), tx_line, frame_bit(b, (c - 1) / DIV));
    end
    chk("tx_ok_low_cycles", ok_low, 10 * DIV);
    exp_q.push_back(b);
  endtask
  task automatic settle(input string tag);
    int low = 0;
    for (int i = 0; i < 2 * DIV; i++) begin
      @(negedge clk);
      if (tx_line !== 1'b1) low++;
    end
    chk({tag, "_tx_idle"}, low, 0);
  endtask
  task automatic expect_rx(input string tag);
    while (exp_q.size() > 0) begin
      chk({tag, "_avail"}, got_q.size() > 0, 1);
      if (got_q.size() > 0) chk({tag, "_data"}, got_q.pop_front(), exp_q[0]);
      last_good = exp_q.pop_front();
    end
    chk({tag, "_extra"}, got_q.size(), 0);
    chk({tag, "_hold"}, bus.RX_DATA, last_good);
    got_q.delete();
  endtask
  task automatic expect_none(input string tag);
    chk({tag, "_nostrobe"}, got_q.size(), 0);
    chk({tag, "_hold"}, bus.RX_DATA, last_good);
    got_q.delete();
    exp_q.delete();
  endtask
  task automatic drive_rx(input logic [7:0] b, input logic stop);
    loop = 1'b0;
    for (int j = 0; j < 10; j++) begin
      rx_drv = (j == 9) ? stop : frame_bit(b, j);
      repeat (DIV) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    if (stop) exp_q.push_back(b);
  endtask
  task automatic start_then_wait(input logic [7:0] b, input int n);
    for (int i = 0; i < 2000 && bus.TX_LOAD_OKAY !== 1'b1; i++) @(negedge clk);
    bus.TX_DATA = b;
    bus.TX_LOAD = 1'b1;
    @(negedge clk);
    bus.TX_LOAD = 1'b0;
    repeat (n) @(negedge clk);
  endtask
  initial begin
    bus.TX_LOAD = 1'b0;
    bus.TX_DATA = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tx_line", tx_line, 1);
    chk("rst_tx_ok", bus.TX_LOAD_OKAY, 0);
    chk("rst_rx_data", bus.RX_DATA, 0);
    chk("rst_rx_rdy", bus.RX_DATA_READY, 0);
    enable = 1'b1;
    @(negedge clk);
    chk("enable_tx_ok", bus.TX_LOAD_OKAY, 1);
    loop = 1'b1;
    repeat (DIV) @(negedge clk);
    send(8'hA5, 1'b1);
    settle("busy_load");
    expect_rx("loop_a5");
    send(8'h81, 1'b0);
    settle("reload");
    expect_rx("loop_81");
    for (int k = 0; k < 4; k++) send(8'($urandom), 1'b0);
    settle("b2b");
    expect_rx("rand_b2b");
    drive_rx(8'h3C, 1'b0);
    expect_none("framing_err");
    drive_rx(8'h3C, 1'b1);
    expect_rx("rx_3c");
    rx_drv = 1'b0;
    repeat (10) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    expect_none("glitch");
    drive_rx(8'($urandom), 1'b1);
    expect_rx("post_glitch");
    loop = 1'b1;
    start_then_wait(8'hF0, 200);
    enable = 1'b0;
    @(negedge clk);
    chk("dis_tx_line", tx_line, 1);
    chk("dis_tx_ok", bus.TX_LOAD_OKAY, 0);
    repeat (12 * DIV) @(negedge clk);
    expect_none("dis_abort");
    enable = 1'b1;
    send(8'hC3, 1'b0);
    settle("after_dis");
    expect_rx("after_dis");
    start_then_wait(8'h0F, 200);
    #1 rst = 1'b1;
    #1;
    chk("rst_abort_tx_line", tx_line, 1);
    chk("rst_abort_tx_ok", bus.TX_LOAD_OKAY, 0);
    last_good = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12 * DIV) @(negedge clk);
    expect_none("rst_abort");
    send(8'($urandom), 1'b0);
    settle("after_rst");
    expect_rx("after_rst");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_controller.md
# uart_controller

Full-duplex 8N1 UART with independent transmit and receive engines sharing one system clock and one baud divider setting. It sits between fabric logic and the device's serial pins. Parallel bytes are serialised on `TX_LINE` under a load/ready handshake. Bytes arriving on `RX_LINE` are deserialised and announced with a one-cycle ready strobe.

## Interface
- `SYSCLK_FREQ`, default 24000000: system clock frequency in Hz.
- `BAUDRATE`, default 500000: line rate in bit/s. `DIV = SYSCLK_FREQ / BAUDRATE` uses integer truncation. `DIV` must be ≥ 4, and the default gives 48.
- `BYTE_W`, default 8: data bits per frame.
- `sys_clk` in 1: system clock. All logic is on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `enable` in 1: block enable. When low, both engines idle.
- `RX_LINE` in 1: serial input, asynchronous to `sys_clk`, idle high.
- `RX_DATA` out `BYTE_W`: last correctly framed received byte.
- `RX_DATA_READY` out 1: one-cycle strobe indicating that `RX_DATA` has been updated.
- `TX_DATA` in `BYTE_W`: byte to send. It is sampled only on an accepted load.
- `TX_LOAD` in 1: load request.
- `TX_LOAD_OKAY` out 1: transmitter is idle and will accept `TX_LOAD` on this edge.
- `TX_LINE` out 1: serial output, idle high.

## Operation
- Frame format:
  - One start bit (0).
  - `BYTE_W` data bits, LSB first.
  - One stop bit (1).
  - No parity.
  - Every bit lasts exactly `DIV` cycles.
- TX states are IDLE, START, DATA, STOP.
- IDLE:
  - `TX_LINE` is 1 and `TX_LOAD_OKAY` is 1 (only when `enable` is 1).
  - `TX_LOAD` & `TX_LOAD_OKAY` latches `TX_DATA` into a shift register and moves to START.
- START to DATA to STOP: each state advances after `DIV` cycles. DATA shifts out `BYTE_W` bits.
- STOP returns to IDLE after `DIV` cycles.
- `TX_LOAD` while `TX_LOAD_OKAY` is 0 is ignored. There is no buffering, and the transmission in progress is not disturbed.
- RX path:
  - `RX_LINE` passes through a two-flop synchroniser.
  - RX states are IDLE, START, DATA, STOP.
- RX IDLE: a synchronised 1→0 transition moves to START.
- RX START:
  - The line is sampled at `DIV/2` cycles.
  - If it is high, this is a glitch and RX returns to IDLE.
  - If it is low, RX moves to DATA.
- RX DATA: `BYTE_W` bits are sampled at the centre of each bit, `DIV` cycles apart, and shifted in LSB first.
- RX STOP: the line is sampled at the centre of the stop bit.
  - If it is 1, `RX_DATA` is loaded and `RX_DATA_READY` pulses for one cycle.
  - If it is 0 (framing error), the byte is discarded, there is no strobe, and `RX_DATA` keeps its old value.
  - In both cases RX returns to IDLE. A new start bit is not accepted until the line has been seen high.
- `enable` low:
  - Both FSMs are forced to IDLE, aborting any frame in progress.
  - `TX_LINE` is 1, `TX_LOAD_OKAY` is 0 and `RX_DATA_READY` is 0.
  - `RX_DATA` is held.
- Reset values:
  - `TX_LINE` = 1.
  - `TX_LOAD_OKAY` = 0.
  - `RX_DATA` = 0.
  - `RX_DATA_READY` = 0.
  - Both FSMs are in IDLE and all counters are 0.
- Reset mid-frame aborts immediately. `TX_LINE` returns high asynchronously.
- Counters are `$clog2(DIV)` bits wide and the bit index is `$clog2(BYTE_W+1)` bits wide. Neither may wrap inside a bit period.

## Timing
- All outputs are registered.
- `TX_LOAD_OKAY` rises on the first edge after `enable` is seen high while TX is idle.
- TX latency:
  - Load accepted at edge N.
  - At edge N+1, `TX_LINE` goes to 0 and `TX_LOAD_OKAY` goes to 0.
  - Data bit k starts at edge N+1+(k+1)·`DIV`.
  - The stop bit starts at N+1+(`BYTE_W`+1)·`DIV`.
  - `TX_LOAD_OKAY` returns to 1 at edge N+1+(`BYTE_W`+2)·`DIV`.
- Back-to-back: a load accepted on the edge where `TX_LOAD_OKAY` is first high starts the next start bit without any extra idle cycle.
- RX latency: `RX_DATA_READY` asserts 9.5·`DIV` + 3 cycles (±1) after the falling edge of the start bit on `RX_LINE`. `RX_DATA` is valid in the same cycle and stays stable until the next good frame.
- A simultaneous TX load and RX stop-bit completion is independent, and both complete normally.

## Test plan
- **Reset and enable:** assert `rst`, then release it with `enable` = 0.
  - Required: `TX_LINE` = 1, `TX_LOAD_OKAY` = 0, `RX_DATA` = 0 and `RX_DATA_READY` = 0.
  - Then raise `enable`. Required: `TX_LOAD_OKAY` = 1 one cycle later.
- **Loopback of 0xA5:** connect `TX_LINE` to `RX_LINE` with `DIV` = 48 and pulse `TX_LOAD` with 0xA5.
  - Required `TX_LINE` sequence, in 48-cycle bits: 0, then 1,0,1,0,0,1,0,1, then 1.
  - Required: `TX_LOAD_OKAY` is low for exactly 480 cycles.
  - Required: one `RX_DATA_READY` pulse, with `RX_DATA` = 0xA5.
- **Load while busy:** 400 cycles into the 0xA5 frame, pulse `TX_LOAD` with 0x81.
  - Required: the load is ignored, so 0xA5 completes and no 0x81 frame follows.
  - Then reload 0x81 after `TX_LOAD_OKAY` rises. Required: `RX_DATA` = 0x81.
- **Framing error:** drive `RX_LINE` directly with 0x3C and the stop bit held at 0.
  - Required: no strobe, and `RX_DATA` keeps its prior value.
  - Then send 0x3C with a proper stop bit. Required: a strobe with `RX_DATA` = 0x3C.
- **Glitch rejection:** pulse `RX_LINE` low for 10 cycles (less than `DIV/2`). Required: no strobe and RX back in IDLE.
- **Abort:** deassert `enable` mid-frame, then assert `rst` mid-frame.
  - Required in both cases: `TX_LINE` = 1 immediately or on the next edge, and no `RX_DATA_READY` pulse.
  - Required: the next load sends a clean full frame.
